// File: rtl/channel_scheduler.sv
// Round-robin wormhole scheduler sharing one tx channel among N_REQ inputs.
// Optional stall watchdog enabled by defining CHSCHED_TIMEOUT_EN.
module channel_scheduler #(
   parameter int N_REQ   = 4,
   parameter int IDX_W   = 2,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] last,
   input  logic             busy,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] owner,
   output logic             active,
   output logic             xfer,
   output logic             timeout
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;

   logic [IDX_W-1:0] sel;
   logic [N_REQ-1:0] sel_oh;
   logic             hit;
   logic             own_req;
   logic             own_last;
   logic [IDX_W-1:0] next_ptr;
   logic             xfer_w;
   logic             stall_hit;
   logic             release_w;

   // Two descending passes: the later pass (indices >= ptr) overrides,
   // so the lowest index at or above ptr wins, else the lowest below ptr.
   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[k] && (k < int'(ptr_q))) begin
            hit = 1'b1;
            sel = IDX_W'(k);
         end
      end
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[k] && (k >= int'(ptr_q))) begin
            hit = 1'b1;
            sel = IDX_W'(k);
         end
      end
   end

   always_comb begin
      sel_oh = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (sel == IDX_W'(k)) sel_oh[k] = 1'b1;
      end
   end

   always_comb begin
      own_req  = 1'b0;
      own_last = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (owner_q == IDX_W'(k)) begin
            own_req  = req[k];
            own_last = last[k];
         end
      end
   end

   // Pointer wraps at N_REQ, not at 2**IDX_W.
   assign next_ptr = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

   assign xfer_w    = (state_q == HOLD) && own_req && !busy;
   assign release_w = (xfer_w && own_last) || stall_hit;

`ifdef CHSCHED_TIMEOUT_EN
   logic [7:0] stall_q, stall_d;
   logic       timeout_q, timeout_d;

   assign stall_hit = (state_q == HOLD) && !xfer_w &&
                      (stall_q == 8'(TIMEOUT - 1));

   always_comb begin
      stall_d   = stall_q;
      timeout_d = stall_hit;
      if (state_q != HOLD || xfer_w || stall_hit) begin
         stall_d = '0;
      end else begin
         stall_d = stall_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         stall_q   <= stall_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign stall_hit = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      gnt_d   = gnt_q;
      unique case (state_q)
         IDLE: begin
            if (!busy && hit) begin
               state_d = HOLD;
               owner_d = sel;
               gnt_d   = sel_oh;
            end
         end
         HOLD: begin
            if (release_w) begin
               state_d = IDLE;
               owner_d = '0;
               gnt_d   = '0;
               ptr_d   = next_ptr;
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = '0;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
      end
   end

   assign gnt    = gnt_q;
   assign owner  = owner_q;
   assign active = (state_q == HOLD);
   assign xfer   = xfer_w;

endmodule

// File: tb/tb_channel_scheduler.sv
// Directed testbench for channel_scheduler (N_REQ=4, TIMEOUT=8).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_channel_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] last;
   logic       busy;
   logic [3:0] gnt;
   logic [1:0] owner;
   logic       active;
   logic       xfer;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   channel_scheduler #(
      .N_REQ  (4),
      .IDX_W  (2),
      .TIMEOUT(8)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .last   (last),
      .busy   (busy),
      .gnt    (gnt),
      .owner  (owner),
      .active (active),
      .xfer   (xfer),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Leaves the bench at a falling edge with reset low: cycle 0.
   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      last  = '0;
      busy  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req   = 4'b1111;
      last  = '0;
      busy  = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (gnt !== 4'b0000 || owner !== 2'd0 || active !== 1'b0 ||
          xfer !== 1'b0 || timeout !== 1'b0) begin
         bad++;
         $display("FAIL reset gnt=%b owner=%0d act=%b xfer=%b to=%b want 0",
                  gnt, owner, active, xfer, timeout);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] exp [6];
      exp = '{4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001};
      do_reset();
      req  = 4'b0101;
      last = 4'b1111;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         total++;
         if (gnt !== exp[c] || xfer !== (exp[c] != 4'b0000)) begin
            bad++;
            $display("FAIL rotation c%0d gnt=%b xfer=%b want gnt=%b xfer=%b",
                     c, gnt, xfer, exp[c], exp[c] != 4'b0000);
         end
      end
   endtask

   task automatic test_packet_lock();
      do_reset();
      req  = 4'b0011;
      last = 4'b0000;
      #1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         last = (c == 3) ? 4'b0001 : 4'b0000;
         #1;
         total++;
         if (gnt !== 4'b0001 || xfer !== 1'b1 || owner !== 2'd0) begin
            bad++;
            $display("FAIL lock c%0d gnt=%b xfer=%b owner=%0d want 0001/1/0",
                     c, gnt, xfer, owner);
         end
      end
      @(negedge clk);
      last = 4'b0000;
      #1;
      total++;
      if (gnt !== 4'b0000 || active !== 1'b0) begin
         bad++;
         $display("FAIL lock_gap gnt=%b act=%b want 0000/0", gnt, active);
      end
      @(negedge clk);
      #1;
      total++;
      if (gnt !== 4'b0010 || owner !== 2'd1) begin
         bad++;
         $display("FAIL lock_next gnt=%b owner=%0d want 0010/1", gnt, owner);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      req  = 4'b0100;
      last = 4'b0100;
      #1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         busy = 1'b1;
         #1;
         total++;
         if (gnt !== 4'b0100 || xfer !== 1'b0) begin
            bad++;
            $display("FAIL bp_stall c%0d gnt=%b xfer=%b want 0100/0",
                     c, gnt, xfer);
         end
      end
      @(negedge clk);
      busy = 1'b0;
      req  = 4'b1100;
      #1;
      total++;
      if (gnt !== 4'b0100 || xfer !== 1'b1) begin
         bad++;
         $display("FAIL bp_xfer gnt=%b xfer=%b want 0100/1", gnt, xfer);
      end
      @(negedge clk);
      #1;
      total++;
      if (gnt !== 4'b0000) begin
         bad++;
         $display("FAIL bp_gap gnt=%b want 0000", gnt);
      end
      @(negedge clk);
      #1;
      total++;
      if (gnt !== 4'b1000 || owner !== 2'd3) begin
         bad++;
         $display("FAIL bp_ptr gnt=%b owner=%0d want 1000/3", gnt, owner);
      end
   endtask

   task automatic test_idle_busy_wrap();
      do_reset();
      req  = 4'b1000;
      last = 4'b1000;
      busy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         total++;
         if (gnt !== 4'b0000) begin
            bad++;
            $display("FAIL idle_busy c%0d gnt=%b want 0000", c, gnt);
         end
      end
      busy = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (gnt !== 4'b1000 || xfer !== 1'b1 || owner !== 2'd3) begin
         bad++;
         $display("FAIL wrap_grant gnt=%b xfer=%b owner=%0d want 1000/1/3",
                  gnt, xfer, owner);
      end
      @(negedge clk);
      req  = 4'b1001;
      last = 4'b0000;
      #1;
      @(negedge clk);
      #1;
      total++;
      if (gnt !== 4'b0001 || owner !== 2'd0) begin
         bad++;
         $display("FAIL wrap_ptr gnt=%b owner=%0d want 0001/0", gnt, owner);
      end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      req  = 4'b0010;
      last = 4'b0000;
      #1;
      @(negedge clk);
      #1;
      total++;
      if (gnt !== 4'b0010 || owner !== 2'd1 || active !== 1'b1) begin
         bad++;
         $display("FAIL mid_setup gnt=%b owner=%0d act=%b want 0010/1/1",
                  gnt, owner, active);
      end
      #1;
      reset = 1'b1;
      #1;
      total++;
      if (gnt !== 4'b0000 || active !== 1'b0 || owner !== 2'd0) begin
         bad++;
         $display("FAIL mid_async gnt=%b act=%b owner=%0d want 0000/0/0",
                  gnt, active, owner);
      end
      @(negedge clk);
      reset = 1'b0;
      req   = 4'b0110;
      #1;
      @(negedge clk);
      #1;
      total++;
      if (gnt !== 4'b0010 || owner !== 2'd1) begin
         bad++;
         $display("FAIL mid_regrant gnt=%b owner=%0d want 0010/1", gnt, owner);
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      req  = 4'b0011;
      last = 4'b0000;
      #1;
      @(negedge clk);
      busy = 1'b1;
      #1;
      total++;
      if (gnt !== 4'b0001 || xfer !== 1'b0) begin
         bad++;
         $display("FAIL wd_grant gnt=%b xfer=%b want 0001/0", gnt, xfer);
      end
`ifdef CHSCHED_TIMEOUT_EN
      for (int c = 2; c <= 8; c++) begin
         @(negedge clk);
         #1;
         total++;
         if (gnt !== 4'b0001 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL wd_hold c%0d gnt=%b to=%b want 0001/0",
                     c, gnt, timeout);
         end
      end
      @(negedge clk);
      busy = 1'b0;
      #1;
      total++;
      if (gnt !== 4'b0000 || timeout !== 1'b1) begin
         bad++;
         $display("FAIL wd_fire gnt=%b to=%b want 0000/1", gnt, timeout);
      end
      @(negedge clk);
      #1;
      total++;
      if (gnt !== 4'b0010 || timeout !== 1'b0) begin
         bad++;
         $display("FAIL wd_next gnt=%b to=%b want 0010/0", gnt, timeout);
      end
`else
      for (int c = 2; c <= 21; c++) begin
         @(negedge clk);
         #1;
         total++;
         if (gnt !== 4'b0001 || timeout !== 1'b0 || active !== 1'b1) begin
            bad++;
            $display("FAIL wd_hold c%0d gnt=%b to=%b act=%b want 0001/0/1",
                     c, gnt, timeout, active);
         end
      end
`endif
      busy = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      last  = '0;
      busy  = 1'b0;
      test_reset();
      test_rotation();
      test_packet_lock();
      test_backpressure();
      test_idle_busy_wrap();
      test_reset_mid_packet();
      test_watchdog();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/channel_scheduler.md
Name: channel_scheduler

Overview:
- Per-output-channel packet scheduler for the router crossbar.
- Shares one tx channel among N_REQ input channels using round-robin arbitration.
- Locks the grant to one input for a whole multi-item packet (wormhole) until the tail item transfers.
- Produces a valid-transfer strobe that drives channel enable, input read and crossbar select.

Parameters:
- N_REQ, 4, number of requesting input channels.
- IDX_W, 2, width of owner index; must satisfy N_REQ <= 2**IDX_W.
- TIMEOUT, 16, stall-cycle limit for the optional watchdog; legal range 2..255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  req[k]=1: input k is non-empty and its head item routes to this channel.
- last  in  N_REQ  last[k]=1: input k's head item is the packet tail.
- busy  in  1  downstream channel cannot accept an item this cycle.
- gnt  out  N_REQ  registered one-hot grant; all-zero when idle.
- owner  out  IDX_W  registered index of the granted input; 0 when idle.
- active  out  1  registered; 1 in HOLD state.
- xfer  out  1  combinational: active & req[owner] & !busy; one item moves this cycle.
- timeout  out  1  registered one-cycle pulse; present only with the optional feature, else tied 0.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, gnt=0, owner=0, active=0, ptr=0, stall counter=0, timeout=0.
- Registers: state, ptr[IDX_W-1:0], gnt, owner, stall counter.
- IDLE state:
  - If busy=0 and req!=0, sel = first k with req[k]=1, searching ptr, ptr+1, ... modulo N_REQ.
  - Next edge: gnt=onehot(sel), owner=sel, state=HOLD.
  - If busy=1 or req=0, stay in IDLE with no grant.
  - Arbitration latency: req seen in cycle t gives gnt visible in cycle t+1; earliest xfer is cycle t+1.
- HOLD state:
  - gnt and owner are held constant.
  - xfer=1 whenever req[owner]=1 and busy=0.
  - xfer=1 and last[owner]=1: release. Next edge: state=IDLE, gnt=0, owner=0, ptr=(owner+1) mod N_REQ.
  - req[owner]=0 (input drained mid-packet): grant is held; the packet still owns the channel.
  - busy=1: no transfer, grant is held, and last is ignored.
- Inter-packet gap: after release, one IDLE arbitration cycle always precedes the next grant (one bubble per packet).
- Fairness: the releasing input becomes lowest priority. Requests from other inputs do not affect HOLD.
- Wrap-around: ptr increments modulo N_REQ, not modulo 2**IDX_W. ptr=N_REQ-1 advances to 0.
- Request bits at indices >= N_REQ do not exist; owner never exceeds N_REQ-1.
- Simultaneous tail transfer and new requests: release wins; the new arbitration happens in the following IDLE cycle using the updated ptr.
- Reset asserted in HOLD: grant drops asynchronously and the partial packet is abandoned.

Optional Feature:
- Macro: CHSCHED_TIMEOUT_EN.
- Defined:
  - In HOLD, an 8-bit stall counter increments each cycle with xfer=0 and clears on any xfer.
  - When the counter reaches TIMEOUT-1 while xfer=0, force release at the next edge: state=IDLE, ptr=owner+1, counter=0.
  - timeout pulses 1 for exactly the cycle after that edge.
  - The counter clears on entry to IDLE.
- Undefined: no counter is built, HOLD lasts indefinitely, timeout is constant 0.

Test Plan:
- Round-robin rotation: N_REQ=4, reset, req=4'b0101 held, last=4'b1111, busy=0 → gnt sequence 0001, 0000, 0100, 0000, 0001...; xfer=1 in every grant cycle.
- Packet lock: req=4'b0011; input 0 raises last only on its 3rd transfer → gnt=0001 for 3 consecutive xfer cycles, one idle cycle, then gnt=0010, owner=1.
- Backpressure: in HOLD with owner=2 and last[2]=1, busy=1 for 5 cycles → xfer=0 for all 5 and gnt stays 0100. busy drops → one xfer, release, ptr=3.
- Idle under busy, then wrap: IDLE, req=4'b1000, busy=1 for 3 cycles → gnt stays 0. busy=0 → gnt=1000 next cycle. After the tail transfers, req=4'b1001 → gnt=0001 (ptr wrapped to 0).
- Reset mid-packet: owner=1 in HOLD, assert reset between clock edges → gnt=0 and active=0 immediately. After reset deasserts with req=4'b0110 → grant goes to input 1 (ptr=0).
- Watchdog (CHSCHED_TIMEOUT_EN, TIMEOUT=8): grant input 0, busy stuck at 1 → release after 8 stalled cycles, timeout=1 for one cycle, next grant to input 1 if req[1]=1. Without the macro, gnt is held indefinitely.
